rf_seq_ctrl: RTL and testbench
==============================

Name: rf_seq_ctrl

Overview:
Multicycle sequencer for the 16-bit RISC core. It fetches one instruction at a time, drives the register-file read addresses, and waits out the one-cycle registered read latency. It then starts the ALU and waits for completion. Finally it issues a single gated write-back to the register file and advances the PC.

Parameters:
PC_W, 16, program counter / instruction address width
REG_AW, 4, register address width (16 registers)
ZERO_PROTECT, 1, when 1, write-back to register 0 is suppressed

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; enables fetching of instructions
imem_req  output  1  instruction fetch request
imem_addr  output  PC_W  fetch address (equals pc)
imem_ack  input  1  fetch accepted; imem_data valid this cycle
imem_data  input  16  instruction: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt
rf_rs  output  REG_AW  register file read address A
rf_rt  output  REG_AW  register file read address B
rf_rd  output  REG_AW  register file write address
rf_we  output  1  register file write strobe, one cycle per instruction
alu_op  output  4  opcode passed to the ALU
alu_start  output  1  one-cycle ALU start pulse
alu_done  input  1  ALU result valid
pc  output  PC_W  current program counter
halted  output  1  HALT executed

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered. On rst_n=0, immediately and regardless of state:
  - state=IDLE
  - pc=0, imem_addr=0, imem_req=0
  - rf_rs=rf_rt=rf_rd=0, rf_we=0
  - alu_op=0, alu_start=0, halted=0
  - instruction latch cleared
- States: IDLE, FETCH, DECODE, RDWAIT, EXEC, WB, HALT.
- IDLE: wait for run=1, then go to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On the first posedge with imem_req=1 and imem_ack=1: latch imem_data, drop imem_req, go to DECODE.
  - Arbitrary wait states are allowed. An ack with req low is ignored.
- DECODE:
  - rf_rs=instr[7:4], rf_rt=instr[3:0], rf_rd=instr[11:8], alu_op=instr[15:12].
  - These outputs hold stable until the next DECODE or reset.
  - op=4'hF (HALT): go to HALT.
  - op=4'hE (NOP): go to WB with the write suppressed.
  - Any other op: go to RDWAIT.
- RDWAIT: exactly one cycle; covers the register file's registered read. Go to EXEC.
- EXEC:
  - alu_start=1 in the first EXEC cycle only.
  - alu_done is sampled from that first cycle onward, so a same-cycle done is legal.
  - On alu_done=1, go to WB. alu_done is ignored in every other state.
- WB:
  - rf_we=1 for exactly one cycle.
  - rf_we is forced to 0 for NOP, and for rd=0 when ZERO_PROTECT=1.
  - pc <= pc+1, wrapping 2^PC_W-1 to 0.
  - Next state is FETCH if run=1, else IDLE.
- HALT:
  - halted=1; pc is not incremented.
  - No further fetches; run is ignored. Exit only via rst_n.
- run is sampled only in IDLE and WB. Deasserting run mid-instruction completes that instruction.
- Minimum instruction latency is 5 cycles: FETCH, DECODE, RDWAIT, EXEC, WB, with zero-wait ack and same-cycle done. NOP takes 3 cycles.
- rf_we is never high outside WB.

Test Plan:
- Reset values: assert rst_n=0 mid-EXEC with alu_start high → all outputs 0 and state IDLE asynchronously. Release with run=0 → imem_req stays 0.
- Single op: run=1, imem_data=16'h1312, ack same cycle, alu_done one cycle after alu_start → expect:
  - rf_rs=1, rf_rt=2, rf_rd=3, alu_op=1
  - rf_we high on cycle 6 after fetch start
  - pc=1 afterwards
- Memory wait states: hold imem_ack=0 for 3 cycles → imem_req stays high and imem_addr constant; DECODE begins the cycle after ack.
- Zero-register protection: instruction 16'h2045 → rf_we stays 0 in WB and pc still increments. With ZERO_PROTECT=0, rf_we=1.
- HALT and NOP: program NOP(16'hE000) then HALT(16'hF000) → NOP takes 3 cycles and advances pc to 1. After HALT, halted=1, pc=1, and imem_req=0 for 20 cycles regardless of run.
- PC wrap: preload by executing until pc=16'hFFFF (or force), one op → pc=0. Deassert run during EXEC → finishes WB, goes to IDLE.

Source files
------------

// File: rtl/rf_seq_ctrl_if.sv
// Bus bundle between the sequencer and its instruction memory, register file
// and ALU. The sequencer is the master side; memory/RF/ALU form the slave side.
interface rf_seq_ctrl_if #(
  parameter int PC_W   = 16,
  parameter int REG_AW = 4
);
  // Handshakes: a fetch transfers on the posedge where imem_req and imem_ack
  // are both high (imem_data valid that cycle; ack with req low means nothing).
  // alu_start is a one-cycle pulse; alu_done may answer in that same cycle or
  // any later one. rf_we is a single-cycle strobe qualifying rf_rd.
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_data;
  logic [REG_AW-1:0] rf_rs;
  logic [REG_AW-1:0] rf_rt;
  logic [REG_AW-1:0] rf_rd;
  logic              rf_we;
  logic [3:0]        alu_op;
  logic              alu_start;
  logic              alu_done;

  modport master (
    output imem_req, imem_addr, rf_rs, rf_rt, rf_rd, rf_we, alu_op, alu_start,
    input  imem_ack, imem_data, alu_done
  );

  modport slave (
    input  imem_req, imem_addr, rf_rs, rf_rt, rf_rd, rf_we, alu_op, alu_start,
    output imem_ack, imem_data, alu_done
  );
endinterface

// File: rtl/rf_seq_ctrl.sv
// Multicycle sequencer for the 16-bit RISC core: fetch, decode, register-read
// wait, ALU execute, single gated write-back, then PC advance.
module rf_seq_ctrl #(
  parameter int PC_W         = 16,
  parameter int REG_AW       = 4,
  parameter int ZERO_PROTECT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  rf_seq_ctrl_if.master    bus,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [2:0]       dbg_state   // 0=IDLE 1=FETCH 2=DECODE 3=RDWAIT 4=EXEC 5=WB 6=HALT
);

  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_RDWAIT = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic              halted_q, halted_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [3:0]        op_q, op_d;
  logic              fetch_fire;
  logic              wb_allowed;

  assign fetch_fire = (state_q == S_FETCH) && req_q && bus.imem_ack;

  // The latched instruction decides whether the WB cycle really writes.
  assign wb_allowed = (instr_q[15:12] != OP_NOP) &&
                      !((ZERO_PROTECT != 0) && (instr_q[11:8] == 4'h0));

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_fire) begin
          state_d = S_DECODE;
          instr_d = bus.imem_data;
          // Addresses are presented during DECODE so the registered RF read
          // completes by the end of RDWAIT.
          rs_d    = REG_AW'(bus.imem_data[7:4]);
          rt_d    = REG_AW'(bus.imem_data[3:0]);
          rd_d    = REG_AW'(bus.imem_data[11:8]);
          op_d    = bus.imem_data[15:12];
        end
      end
      S_DECODE: begin
        if (instr_q[15:12] == OP_HALT)     state_d = S_HALT;
        else if (instr_q[15:12] == OP_NOP) state_d = S_WB;
        else                               state_d = S_RDWAIT;
      end
      S_RDWAIT: state_d = S_EXEC;
      S_EXEC:   if (bus.alu_done) state_d = S_WB;
      S_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    // Outputs are registered, so they are computed from the upcoming state.
    req_d    = (state_d == S_FETCH);
    we_d     = (state_d == S_WB) && wb_allowed;
    start_d  = (state_q == S_RDWAIT);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      halted_q <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      we_q     <= we_d;
      start_q  <= start_d;
      halted_q <= halted_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      op_q     <= op_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.rf_rs     = rs_q;
  assign bus.rf_rt     = rt_q;
  assign bus.rf_rd     = rd_q;
  assign bus.rf_we     = we_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_start = start_q;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Bench for rf_seq_ctrl: directed scenarios plus randomized instruction streams,
// checked against an instruction-level reference model with a scoreboard queue.
module tb_rf_seq_ctrl;
  localparam int PC_W   = 16;
  localparam int REG_AW = 4;
  localparam int W      = 33;   // {op, rd, rs, rt, we, pc}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic run   = 1'b0;
  always #5 clk = ~clk;

  rf_seq_ctrl_if #(.PC_W(PC_W), .REG_AW(REG_AW)) bus ();
  rf_seq_ctrl_if #(.PC_W(PC_W), .REG_AW(REG_AW)) bus_nzp ();

  logic [PC_W-1:0] pc, pc_nzp;
  logic            halted, halted_nzp;
  logic [2:0]      dbg_state, dbg_state_nzp;

  // Second instance without zero-register protection runs in lockstep.
  assign bus_nzp.imem_ack  = bus.imem_ack;
  assign bus_nzp.imem_data = bus.imem_data;
  assign bus_nzp.alu_done  = bus.alu_done;

  rf_seq_ctrl #(.PC_W(PC_W), .REG_AW(REG_AW), .ZERO_PROTECT(1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .bus(bus),
    .pc(pc), .halted(halted), .dbg_state(dbg_state)
  );

  rf_seq_ctrl #(.PC_W(PC_W), .REG_AW(REG_AW), .ZERO_PROTECT(0)) dut_nzp (
    .clk(clk), .rst_n(rst_n), .run(run), .bus(bus_nzp),
    .pc(pc_nzp), .halted(halted_nzp), .dbg_state(dbg_state_nzp)
  );

  // ---------------- scoreboard ----------------
  int              n_checks = 0;
  int              n_errs   = 0;
  logic [W-1:0]    exp_q[$];
  logic [PC_W-1:0] m_pc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of one instruction as seen in its write-back cycle.
  function automatic logic [W-1:0] predict(input logic [15:0] ins, input logic [PC_W-1:0] at_pc);
    logic [3:0] op;
    logic [3:0] rd;
    logic       we;
    op = ins[15:12];
    rd = ins[11:8];
    we = (op != 4'hE) && (rd != 4'h0);
    return {op, rd, ins[7:4], ins[3:0], we, at_pc};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    run           = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.alu_done  = 1'b0;
    bus.imem_data = '0;
    repeat (2) step();
    rst_n = 1'b1;
    m_pc  = '0;
    exp_q.delete();
  endtask

  // Entered with the DUT in its fetch cycle; w memory wait states, ALU done
  // d cycles after the start pulse; run_after is what run holds at WB.
  task automatic run_instr(input logic [15:0] ins, input int w, input int d, input logic run_after);
    logic [W-1:0] exp;
    logic [W-1:0] got;
    logic [3:0]   op;
    op = ins[15:12];
    check_eq("fetch_req", {bus.imem_req, bus.imem_addr}, {1'b1, m_pc});
    if (op != 4'hF) exp_q.push_back(predict(ins, m_pc));
    for (int i = 0; i < w; i++) begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = 16'($urandom);
      bus.alu_done  = 1'($urandom_range(0, 1));
      run           = 1'($urandom_range(0, 1));
      step();
      check_eq("wait_req", {bus.imem_req, bus.imem_addr}, {1'b1, m_pc});
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = ins;
    step();
    bus.imem_ack  = 1'($urandom_range(0, 1));
    bus.imem_data = 16'($urandom);
    bus.alu_done  = 1'($urandom_range(0, 1));
    run           = 1'($urandom_range(0, 1));
    check_eq("decode_req", {bus.imem_req, bus.rf_we, bus.alu_start}, 3'b000);
    if (op == 4'hF) begin
      step();
      bus.imem_ack = 1'b0;
      check_eq("halt_enter", {halted, bus.imem_req, pc}, {1'b1, 1'b0, m_pc});
      return;
    end
    if (op != 4'hE) begin
      step();
      check_eq("rdwait", {bus.alu_start, bus.rf_we}, 2'b00);
      bus.imem_ack = 1'b0;
      bus.alu_done = 1'($urandom_range(0, 1));
      step();
      check_eq("alu_start", {bus.alu_start, bus.rf_we}, 2'b10);
      run = run_after;
      for (int i = 0; i < d; i++) begin
        bus.alu_done = 1'b0;
        step();
        check_eq("exec_hold", {bus.alu_start, bus.rf_we}, 2'b00);
      end
      bus.alu_done = 1'b1;
      step();
    end else begin
      bus.imem_ack = 1'b0;
      step();
    end
    bus.imem_ack = 1'b0;
    bus.alu_done = 1'($urandom_range(0, 1));
    run          = run_after;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 1'b1, 1'b0);
    end else begin
      exp = exp_q.pop_front();
      got = {bus.alu_op, bus.rf_rd, bus.rf_rs, bus.rf_rt, bus.rf_we, pc};
      check_eq("wb", got, exp);
    end
    check_eq("wb_nzp", bus_nzp.rf_we, op != 4'hE);
    m_pc = m_pc + 1'b1;
    step();
    check_eq("after_wb", {bus.imem_req, bus.imem_addr, bus.rf_we}, {run_after, m_pc, 1'b0});
  endtask

  task automatic idle_then_run(input int k);
    for (int i = 0; i < k; i++) begin
      step();
      check_eq("idle_req", bus.imem_req, 1'b0);
    end
    run = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ins;
    logic        ra;

    do_reset();

    // Asynchronous reset while the ALU start pulse is high.
    run = 1'b1;
    step();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h1312;
    step();
    bus.imem_ack = 1'b0;
    step();
    step();
    check_eq("pre_rst_start", bus.alu_start, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_start", bus.alu_start, 1'b0);
    check_eq("rst_ctl", {bus.imem_req, bus.rf_we, halted}, 3'b000);
    check_eq("rst_regs", {bus.rf_rs, bus.rf_rt, bus.rf_rd, bus.alu_op}, 16'h0000);
    check_eq("rst_pc", {pc, bus.imem_addr}, 32'h0);
    check_eq("rst_state", {dbg_state, dbg_state_nzp}, 6'd0);
    run = 1'b0;
    step();
    rst_n = 1'b1;
    m_pc  = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_idle_req", bus.imem_req, 1'b0);
    end

    // Single op, zero-wait fetch, done one cycle after start.
    run = 1'b1;
    step();
    run_instr(16'h1312, 0, 1, 1'b1);
    check_eq("single_pc", pc, 16'd1);
    // Memory wait states, then zero-register protection.
    run_instr(16'h4567, 3, 0, 1'b1);
    run_instr(16'h2045, 0, 2, 1'b1);

    // Randomized instruction stream, random stalls and run gaps.
    for (int n = 0; n < 40; n++) begin
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      ra  = ($urandom_range(0, 3) != 0);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), ra);
      if (!ra) idle_then_run($urandom_range(0, 3));
    end
    run_instr(16'h1abc, 0, 0, 1'b0);

    // PC wrap with run dropped during EXEC.
    force dut.pc_q = 16'hFFFF;
    #1;
    release dut.pc_q;
    m_pc = 16'hFFFF;
    run  = 1'b1;
    step();
    run_instr(16'h3123, 1, 1, 1'b0);
    step();
    check_eq("wrap_idle", {bus.imem_req, pc}, {1'b0, 16'h0000});

    // NOP then HALT from a fresh reset.
    do_reset();
    run = 1'b1;
    step();
    run_instr(16'hE000, 0, 0, 1'b1);
    run_instr(16'hF000, 0, 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run          = 1'($urandom_range(0, 1));
      bus.imem_ack = 1'($urandom_range(0, 1));
      step();
      check_eq("halt_hold", {halted, bus.imem_req, bus.rf_we, pc}, {1'b1, 1'b0, 1'b0, 16'd1});
    end
    check_eq("halt_nzp", {halted_nzp, pc_nzp}, {1'b1, 16'd1});
    check_eq("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
